uart_sram_loader: RTL
=====================

Name: uart_sram_loader

Overview:
Upstream feeder for the SRAM controller in the uart2sram path. It takes the byte stream from the UART receiver and packs every four bytes, little-endian, into one 32-bit word. It issues one write request per word to the SRAM controller's enable/write/address/data interface, with incrementing halfword-pair addresses. A single holding register absorbs one word of SRAM latency, and loss of data beyond that is flagged.

Parameters:
ADDR_W, 16, width of the address driven to the SRAM controller
BASE_ADDR, 16'h0000, address of the first word after each start
WORD_LIMIT, 1024, number of words written before the block reports done (must be at least 1)

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  synchronous, active-low reset
start  in  1  one-cycle pulse; arms the loader
rx_data  in  8  received UART byte
rx_valid  in  1  one-cycle strobe; rx_data valid
sram_en  out  1  request enable to the SRAM controller
sram_write  out  1  write select; equals sram_en (the block never reads)
sram_addr  out  ADDR_W  word address for the SRAM controller
sram_wdata  out  32  word data for the SRAM controller
sram_write_done  in  1  controller completion pulse
busy  out  1  high in ARMED, or while any write is in flight or pending
done  out  1  high in DONE
overflow  out  1  sticky; a completed word was dropped
word_count  out  16  words committed to SRAM since the last start

Behaviour:
- Reset (rst low at an edge) drives all outputs to 0 and sets sram_addr to BASE_ADDR. It clears the byte lane counter, the pack register, pend_valid, the FSM (to IDLE) and the write channel. Any in-flight request is dropped on that edge and any partial word is discarded.
- Main FSM, states IDLE, ARMED, DONE:
  - IDLE or DONE, start=1: go to ARMED. Clear lane, word_count, overflow and the issued-word count. Set the next address to BASE_ADDR.
  - start is ignored in ARMED.
  - rx_valid is ignored outside ARMED.
- Packing (ARMED only): byte k (k = 0..3) of a word lands in bits [8k+7:8k], so the first byte is the LSB. Lane increments on each rx_valid and wraps 3→0. The word completes on the cycle lane=3 is accepted.
- Issue gating: once WORD_LIMIT words have been issued or pended, further rx_valid is ignored.
- Write channel, states W_IDLE, W_BUSY, W_GAP:
  - Word completes and channel is W_IDLE: on the next edge sram_en=sram_write=1, sram_wdata=word, sram_addr=next address. Enter W_BUSY.
  - In W_BUSY, sram_en/sram_write/addr/data hold stable until sram_write_done is sampled high.
  - On sampling sram_write_done: deassert sram_en, increment word_count, advance the address by 2 (mod 2^ADDR_W), enter W_GAP.
  - W_GAP lasts exactly one cycle with sram_en=0, because the controller triggers on the write edge. Then, if pend_valid, issue the pending word and clear pend_valid; otherwise return to W_IDLE.
  - sram_write_done sampled while not in W_BUSY is ignored.
- Buffering:
  - A word that completes while the channel is W_BUSY or W_GAP and pend_valid=0 goes into the pend register, and pend_valid is set.
  - A word that completes while pend_valid=1 is discarded and overflow is set (sticky until start or rst). It does not count toward WORD_LIMIT or word_count.
- Completion: when word_count reaches WORD_LIMIT (on the write_done edge), the channel ends idle, the FSM goes to DONE, done=1 and busy=0.
- A word completing in the same cycle that write_done is sampled goes to pend; it never bypasses W_GAP.

Test Plan:
1. Reset, start, then bytes 11,22,33,44; controller returns done 3 cycles after sram_en rises → sram_en rises 1 cycle after byte 4 with wdata=32'h44332211, addr=16'h0000; word_count=1; sram_en low the cycle after done.
2. Eight back-to-back bytes 11..88 → two writes: 32'h44332211 at 0x0000, then 32'h88776655 at 0x0002. Exactly one sram_en-low cycle between them; word_count=2.
3. Hold sram_write_done low and send 12 bytes → word 0 in flight, word 1 pending, word 2 dropped, overflow=1. Release done pulses → exactly two writes occur; word_count=2; overflow stays 1.
4. WORD_LIMIT=2: after the second write_done, done=1 and busy=0. Bytes sent now cause no sram_en. A start pulse gives done=0, word_count=0, and the next write goes to BASE_ADDR.
5. Pull rst low while sram_en=1, with 3 bytes of the next word collected → next edge: sram_en=0, word_count=0, FSM IDLE. After start plus 4 bytes, the word is written at BASE_ADDR and contains only the new bytes.
6. BASE_ADDR=16'hFFFE, two words → addresses 16'hFFFE then 16'h0000 (wrap).

Source files
------------

// File: rtl/uart_sram_loader.sv
// uart_sram_loader: packs the UART byte stream into little-endian 32-bit words
// and writes them to the SRAM controller at incrementing halfword-pair addresses.
// One pending-word register covers a single word of SRAM latency; a word lost
// beyond that sets a sticky overflow flag.
module uart_sram_loader #(
   parameter int                ADDR_W     = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = 16'h0000,
   parameter int                WORD_LIMIT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              sram_en,
   output logic              sram_write,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [31:0]       sram_wdata,
   input  logic              sram_write_done,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic [15:0]       word_count
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_DONE = 2'd2} fsm_t;
   typedef enum logic [1:0] {W_IDLE = 2'd0, W_BUSY = 2'd1, W_GAP = 2'd2} ch_t;

   localparam logic [31:0]       LIMIT     = 32'(WORD_LIMIT);
   localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(2'd2);

   fsm_t              fsm_r, fsm_n;
   ch_t               ch_r, ch_n;
   logic [1:0]        lane_r, lane_n;
   logic [23:0]       pack_r, pack_n;
   logic              pend_valid_r, pend_valid_n;
   logic [31:0]       pend_data_r, pend_data_n;
   logic [31:0]       issued_r, issued_n;
   logic              en_r, en_n;
   logic [ADDR_W-1:0] addr_r, addr_n;
   logic [31:0]       wdata_r, wdata_n;
   logic [15:0]       count_r, count_n;
   logic              ovf_r, ovf_n;

   logic              accept_s;
   logic              word_done_s;
   logic              last_s;
   logic [31:0]       word_s;

   // Bytes are taken only while armed and before the word budget is used up;
   // last_s marks the write completion that reaches the budget.
   assign accept_s    = (fsm_r == S_ARMED) && rx_valid && (issued_r < LIMIT);
   assign word_done_s = accept_s && (lane_r == 2'd3);
   assign word_s      = {rx_data, pack_r};
   assign last_s      = (ch_r == W_BUSY) && sram_write_done &&
                        (({16'h0000, count_r} + 32'd1) == LIMIT);

   // State register: synchronous active-low reset clears everything.
   always_ff @(posedge clk) begin
      if (!rst) begin
         fsm_r        <= S_IDLE;
         ch_r         <= W_IDLE;
         lane_r       <= 2'd0;
         pack_r       <= 24'h000000;
         pend_valid_r <= 1'b0;
         pend_data_r  <= 32'h00000000;
         issued_r     <= 32'h00000000;
         en_r         <= 1'b0;
         addr_r       <= BASE_ADDR;
         wdata_r      <= 32'h00000000;
         count_r      <= 16'h0000;
         ovf_r        <= 1'b0;
      end else begin
         fsm_r        <= fsm_n;
         ch_r         <= ch_n;
         lane_r       <= lane_n;
         pack_r       <= pack_n;
         pend_valid_r <= pend_valid_n;
         pend_data_r  <= pend_data_n;
         issued_r     <= issued_n;
         en_r         <= en_n;
         addr_r       <= addr_n;
         wdata_r      <= wdata_n;
         count_r      <= count_n;
         ovf_r        <= ovf_n;
      end
   end

   // Next-state logic: byte packing, write channel, word buffering, main FSM.
   always_comb begin
      fsm_n        = fsm_r;
      ch_n         = ch_r;
      lane_n       = lane_r;
      pack_n       = pack_r;
      pend_valid_n = pend_valid_r;
      pend_data_n  = pend_data_r;
      issued_n     = issued_r;
      en_n         = en_r;
      addr_n       = addr_r;
      wdata_n      = wdata_r;
      count_n      = count_r;
      ovf_n        = ovf_r;

      // First byte lands in the least significant lane.
      if (accept_s) begin
         lane_n = lane_r + 2'd1;
         case (lane_r)
            2'd0:    pack_n[7:0]   = rx_data;
            2'd1:    pack_n[15:8]  = rx_data;
            2'd2:    pack_n[23:16] = rx_data;
            default: pack_n        = pack_r;
         endcase
      end else begin
         lane_n = lane_r;
      end

      // Write channel; the address register always holds the next address.
      case (ch_r)
         W_IDLE, W_GAP: begin
            if (pend_valid_r) begin
               en_n         = 1'b1;
               wdata_n      = pend_data_r;
               pend_valid_n = 1'b0;
               ch_n         = W_BUSY;
            end else begin
               ch_n = W_IDLE;
            end
         end
         W_BUSY: begin
            if (sram_write_done) begin
               en_n    = 1'b0;
               count_n = count_r + 16'd1;
               addr_n  = addr_r + ADDR_STEP;
               ch_n    = last_s ? W_IDLE : W_GAP;
            end else begin
               ch_n = W_BUSY;
            end
         end
         default: begin
            en_n = 1'b0;
            ch_n = W_IDLE;
         end
      endcase

      // A finished word goes straight out only to an idle channel with nothing
      // pending; otherwise it is pended, or dropped if the pend slot is full.
      if (word_done_s) begin
         if (pend_valid_r) begin
            ovf_n = 1'b1;
         end else if (ch_r == W_IDLE) begin
            en_n     = 1'b1;
            wdata_n  = word_s;
            ch_n     = W_BUSY;
            issued_n = issued_r + 32'd1;
         end else begin
            pend_data_n  = word_s;
            pend_valid_n = 1'b1;
            issued_n     = issued_r + 32'd1;
         end
      end else begin
         ovf_n = ovf_r;
      end

      // Main FSM; the channel is always idle outside ARMED, so start may
      // rewind the address safely.
      case (fsm_r)
         S_IDLE, S_DONE: begin
            if (start) begin
               fsm_n    = S_ARMED;
               lane_n   = 2'd0;
               count_n  = 16'h0000;
               ovf_n    = 1'b0;
               issued_n = 32'h00000000;
               addr_n   = BASE_ADDR;
            end else begin
               fsm_n = fsm_r;
            end
         end
         S_ARMED: begin
            if (last_s) begin
               fsm_n = S_DONE;
            end else begin
               fsm_n = S_ARMED;
            end
         end
         default: fsm_n = S_IDLE;
      endcase
   end

   // Output decode straight from state registers.
   always_comb begin
      sram_en    = en_r;
      sram_write = en_r;
      sram_addr  = addr_r;
      sram_wdata = wdata_r;
      word_count = count_r;
      overflow   = ovf_r;
      busy       = (fsm_r == S_ARMED) || (ch_r != W_IDLE) || pend_valid_r;
      done       = (fsm_r == S_DONE);
   end

endmodule
